stream_upsizer: RTL and testbench

//  Narrow-to-wide stream width converter; packs Ratio consecutive narrow beats into one wide word.

---
 rtl/stream_upsizer.sv | 108 ++++++++++
 tb/tb_stream_upsizer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_upsizer.sv
// ============================================================================
//  stream_upsizer
//  Packs Ratio consecutive narrow beats into one registered wide word.
//  Optional feature macro: STREAM_UPSIZER_LAST_EN (wlast_i early close, rmask_o)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module stream_upsizer #(
    parameter int NarrowWidth = 32,
    parameter int Ratio       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         w_i,
    input  logic [NarrowWidth-1:0]       wdata_i,
    output logic                         wok_o,
    input  logic                         r_i,
    output logic [NarrowWidth*Ratio-1:0] rdata_o,
    output logic                         rok_o
`ifdef STREAM_UPSIZER_LAST_EN
    ,
    input  logic                         wlast_i,
    output logic [Ratio-1:0]             rmask_o
`endif
);

    localparam int c_WIDE_W = NarrowWidth * Ratio;
    localparam int c_CNT_W  = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_LANE = c_CNT_W'(Ratio - 1);

    logic [c_WIDE_W-1:0] buf_q, buf_d;
    logic [c_CNT_W-1:0]  cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                w_acc, w_drn, w_close;
`ifdef STREAM_UPSIZER_LAST_EN
    logic [Ratio-1:0]    mask_q, mask_d;
`endif

    assign wok_o = ~full_q | r_i;
    assign w_acc = w_i & wok_o;
    assign w_drn = full_q & r_i;

    // A beat can only be accepted while full if the word drains the same
    // cycle, so cnt_q is 0 then and the new beat always lands in lane 0.
    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        full_d = full_q;
`ifdef STREAM_UPSIZER_LAST_EN
        mask_d  = mask_q;
        w_close = (cnt_q == c_LAST_LANE) | wlast_i;
`else
        w_close = (cnt_q == c_LAST_LANE);
`endif
        if (w_acc) begin
            buf_d[int'(cnt_q)*NarrowWidth +: NarrowWidth] = wdata_i;
`ifdef STREAM_UPSIZER_LAST_EN
            if (w_drn) begin
                mask_d = '0;
            end
            mask_d[cnt_q] = 1'b1;
`endif
            full_d = w_close;
            cnt_d  = w_close ? '0 : cnt_q + c_CNT_W'(1);
        end else if (w_drn) begin
            full_d = 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
            mask_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
`ifdef STREAM_UPSIZER_LAST_EN
            mask_q <= '0;
`endif
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
`ifdef STREAM_UPSIZER_LAST_EN
            mask_q <= mask_d;
`endif
        end
    end

    assign rok_o = full_q;

`ifdef STREAM_UPSIZER_LAST_EN
    assign rmask_o = mask_q;

    // Lanes left unwritten by an early-closed word read as zero.
    for (genvar k = 0; k < Ratio; k++) begin : g_lane
        assign rdata_o[k*NarrowWidth +: NarrowWidth] =
            mask_q[k] ? buf_q[k*NarrowWidth +: NarrowWidth] : '0;
    end
`else
    assign rdata_o = buf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stream_upsizer.sv
// ============================================================================
//  tb_stream_upsizer
//  Directed bench for stream_upsizer at Ratio=4 (32-bit) and Ratio=1 (8-bit).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stream_upsizer;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;

    logic          r_w4 = 1'b0, r_r4 = 1'b0;
    logic [31:0]   r_d4 = '0;
    logic          w_wok4, w_rok4;
    logic [127:0]  w_rdata4;

    logic          r_w1 = 1'b0, r_r1 = 1'b0;
    logic [7:0]    r_d1 = '0;
    logic          w_wok1, w_rok1;
    logic [7:0]    w_rdata1;

`ifdef STREAM_UPSIZER_LAST_EN
    logic          r_last4 = 1'b0, r_last1 = 1'b0;
    logic [3:0]    w_mask4;
    logic [0:0]    w_mask1;
`endif

    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk_i = ~clk_i;

    stream_upsizer #(.NarrowWidth(32), .Ratio(4)) u_dut4 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .w_i     (r_w4),
        .wdata_i (r_d4),
        .wok_o   (w_wok4),
        .r_i     (r_r4),
        .rdata_o (w_rdata4),
        .rok_o   (w_rok4)
`ifdef STREAM_UPSIZER_LAST_EN
        ,
        .wlast_i (r_last4),
        .rmask_o (w_mask4)
`endif
    );

    stream_upsizer #(.NarrowWidth(8), .Ratio(1)) u_dut1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .w_i     (r_w1),
        .wdata_i (r_d1),
        .wok_o   (w_wok1),
        .r_i     (r_r1),
        .rdata_o (w_rdata1),
        .rok_o   (w_rok1)
`ifdef STREAM_UPSIZER_LAST_EN
        ,
        .wlast_i (r_last1),
        .rmask_o (w_mask1)
`endif
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    logic [127:0] c_WORD_B = 128'h000000B4_000000B3_000000B2_000000B1;
    logic [127:0] c_WORD_D = 128'h000000D4_000000D3_000000D2_000000D1;
    logic [127:0] c_STREAM [3] = '{128'h00000004_00000003_00000002_00000001,
                                   128'h00000008_00000007_00000006_00000005,
                                   128'h0000000C_0000000B_0000000A_00000009};
    logic [7:0]   c_SEQ1 [5] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h0F};

    initial begin
        #1;
        check("rst_rok4",   w_rok4,   0);
        check("rst_rdata4", w_rdata4, 0);
        check("rst_wok4",   w_wok4,   1);
        check("rst_rok1",   w_rok1,   0);
        check("rst_wok1",   w_wok1,   1);
`ifdef STREAM_UPSIZER_LAST_EN
        check("rst_mask4",  w_mask4,  0);
`endif
        step;
        rst_ni = 1'b1;

        // Basic packing, lane 0 in the low bits
        r_r4 = 1'b1; r_w4 = 1'b1;
        r_d4 = 32'h11; step;
        r_d4 = 32'h22; step;
        r_d4 = 32'h33; step;
        check("pre_close_rok", w_rok4, 0);
        r_d4 = 32'h44; step;
        r_w4 = 1'b0;
        check("pack_rok",   w_rok4,   1);
        check("pack_rdata", w_rdata4, 128'h00000044_00000033_00000022_00000011);
`ifdef STREAM_UPSIZER_LAST_EN
        check("pack_mask",  w_mask4,  4'hF);
`endif
        step;
        check("drain_rok", w_rok4, 0);

        // Reset with two lanes filled
        r_r4 = 1'b0; r_w4 = 1'b1;
        r_d4 = 32'hA1; step;
        r_d4 = 32'hA2; step;
        r_w4 = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("midrst_rok", w_rok4, 0);
        check("midrst_wok", w_wok4, 1);
        step;
        rst_ni = 1'b1;
        r_r4 = 1'b1; r_w4 = 1'b1;
        r_d4 = 32'hB1; step;
        r_d4 = 32'hB2; step;
        r_d4 = 32'hB3; step;
        r_d4 = 32'hB4; step;
        check("postrst_rok",   w_rok4,   1);
        check("postrst_rdata", w_rdata4, c_WORD_B);

        // Back-pressure on the full B word while a new beat waits
        r_r4 = 1'b0; r_d4 = 32'hD1;
        #1;
        check("bp_wok", w_wok4, 0);
        for (int i = 0; i < 3; i++) begin
            step;
            check("bp_hold_rok",   w_rok4,   1);
            check("bp_hold_rdata", w_rdata4, c_WORD_B);
            check("bp_hold_wok",   w_wok4,   0);
        end
        r_r4 = 1'b1;
        #1;
        check("bp_release_wok", w_wok4, 1);
        step;
        check("bp_swap_rok", w_rok4, 0);
        r_d4 = 32'hD2; step;
        r_d4 = 32'hD3; step;
        r_d4 = 32'hD4; step;
        check("bp_lane0_rdata", w_rdata4, c_WORD_D);

        // Twelve beats back to back; first one overlaps the D word drain
        for (int i = 0; i < 12; i++) begin
            r_d4 = 32'(i + 1);
            step;
            check("stream_wok", w_wok4, 1);
            if (i % 4 == 3) begin
                check("stream_rok",   w_rok4,   1);
                check("stream_rdata", w_rdata4, c_STREAM[i/4]);
            end else begin
                check("stream_gap_rok", w_rok4, 0);
            end
        end
        r_w4 = 1'b0;
        step;
        check("stream_end_rok", w_rok4, 0);

`ifdef STREAM_UPSIZER_LAST_EN
        // Early close after two lanes; stale lanes 2,3 must read as zero
        r_w4 = 1'b1;
        r_d4 = 32'hA; step;
        r_d4 = 32'hB; r_last4 = 1'b1; step;
        r_w4 = 1'b0; r_last4 = 1'b0; r_r4 = 1'b0;
        check("last_rok",   w_rok4,   1);
        check("last_mask",  w_mask4,  4'b0011);
        check("last_rdata", w_rdata4, 128'h00000000_00000000_0000000B_0000000A);
        r_r4 = 1'b1;
        step;
        check("last_drain_mask", w_mask4, 4'b0000);
`endif

        // Ratio=1: word every cycle, data delayed by one
        r_w1 = 1'b1; r_r1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            r_d1 = c_SEQ1[i];
            step;
            check("r1_rok",   w_rok1,   1);
            check("r1_rdata", w_rdata1, c_SEQ1[i]);
        end
        r_r1 = 1'b0; r_d1 = 8'h77;
        #1;
        check("r1_bp_wok", w_wok1, 0);
        step;
        check("r1_bp_rdata", w_rdata1, 8'h0F);
        r_r1 = 1'b1;
        #1;
        check("r1_release_wok", w_wok1, 1);
        step;
        check("r1_after_bp_rdata", w_rdata1, 8'h77);
        r_w1 = 1'b0;
        step;
        check("r1_drain_rok", w_rok1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
